// File: rtl/ipsxe_floating_point_log_arb_v1_0.sv
// ipsxe_floating_point_log_arb_v1_0: round-robin, credit-limited sharing of one fixed-latency log core
// among NUM_REQ stream requesters, with in-order tag matching and a FWFT result FIFO.
module ipsxe_floating_point_log_arb_v1_0 #(
  parameter int FLOAT_EXP_WIDTH  = 8,
  parameter int FLOAT_FRAC_WIDTH = 24,
  parameter int NUM_REQ          = 4,
  parameter int FIFO_DEPTH       = 32,
  localparam int W   = FLOAT_EXP_WIDTH + FLOAT_FRAC_WIDTH,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_aclken,
  input  logic [NUM_REQ*W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [W-1:0]         o_core_data,
  output logic                 o_core_valid,
  input  logic [W-1:0]         i_core_result,
  input  logic [2:0]           i_core_flags,
  input  logic                 i_core_valid,
  output logic [W-1:0]         o_res_data,
  output logic [IDW-1:0]       o_res_id,
  output logic [2:0]           o_res_flags,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  input  logic                 i_drain_req,
  output logic                 o_drained,
  output logic                 o_err_orphan
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = W + 3 + IDW;
  typedef enum logic {RUN, DRAIN} state_t;
  state_t         state_q;
  logic [IDW-1:0] rr_ptr_q, gnt_idx;
  logic [AW:0]    cnt_q, cnt_d, tw_q, tr_q, rw_q, rr_q;
  logic [IDW-1:0] tag_q [FIFO_DEPTH];
  logic [RW-1:0]  res_q [FIFO_DEPTH];
  logic [W-1:0]   core_data_q;
  logic           core_valid_q, drained_q, orphan_q;
  logic           gnt_any, credit_ok, hs, tag_empty, core_in, tpop, res_valid, rpop;
  int             idx;
  // Scan downwards so the nearest valid requester after rr_ptr_q is the last one written.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (i_req_valid[IDW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end
  assign credit_ok   = cnt_q < (AW+1)'(FIFO_DEPTH);
  assign hs          = gnt_any & credit_ok & (state_q == RUN) & i_aclken & i_rst_n;
  assign o_req_ready = hs ? NUM_REQ'(1) << gnt_idx : '0;
  assign tag_empty   = tw_q == tr_q;
  assign core_in     = i_core_valid & i_aclken;
  assign tpop        = core_in & ~tag_empty;
  assign res_valid   = rw_q != rr_q;
  assign rpop        = res_valid & i_res_ready & i_aclken;
  assign cnt_d       = cnt_q + (AW+1)'(hs) - (AW+1)'(rpop);
  assign o_core_data  = core_data_q;
  assign o_core_valid = core_valid_q;
  assign o_res_valid  = res_valid;
  assign {o_res_data, o_res_flags, o_res_id} = res_valid ? res_q[rr_q[AW-1:0]] : '0;
  assign o_drained    = drained_q;
  assign o_err_orphan = orphan_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q      <= RUN;
      rr_ptr_q     <= IDW'(NUM_REQ - 1);
      cnt_q        <= '0;
      tw_q         <= '0;
      tr_q         <= '0;
      rw_q         <= '0;
      rr_q         <= '0;
      core_data_q  <= '0;
      core_valid_q <= 1'b0;
      drained_q    <= 1'b0;
      orphan_q     <= 1'b0;
    end else if (i_aclken) begin
      state_q      <= i_drain_req ? DRAIN : RUN;
      drained_q    <= (state_q == DRAIN) & i_drain_req & (cnt_d == '0);
      cnt_q        <= cnt_d;
      core_valid_q <= hs;
      if (hs) begin
        rr_ptr_q    <= gnt_idx;
        tw_q        <= tw_q + 1'b1;
        core_data_q <= i_req_data[gnt_idx*W +: W];
      end
      if (tpop) begin
        tr_q <= tr_q + 1'b1;
        rw_q <= rw_q + 1'b1;
      end
      if (core_in & tag_empty) orphan_q <= 1'b1;
      if (rpop) rr_q <= rr_q + 1'b1;
    end
  always_ff @(posedge i_clk)
    if (i_aclken) begin
      if (hs) tag_q[tw_q[AW-1:0]] <= gnt_idx;
      if (tpop) res_q[rw_q[AW-1:0]] <= {i_core_result, i_core_flags, tag_q[tr_q[AW-1:0]]};
    end
endmodule

// File: tb/tb_ipsxe_floating_point_log_arb_v1_0.sv
// tb_ipsxe_floating_point_log_arb_v1_0: drives the arbiter against a 3-stage behavioural log core,
// checking single ops from a vector table plus RR, credit, drain, clock-enable and reset sequences.
module tb_ipsxe_floating_point_log_arb_v1_0;
  localparam int W = 32, NR = 4, L = 3, IDW = 2;
  logic clk = 1'b0;
  logic rst_n, aclken, core_valid, res_valid, res_ready, drain, drained, orphan, core_in_valid, inj_v;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   req_valid, req_ready;
  logic [W-1:0]    core_data, core_result, res_data;
  logic [2:0]      core_flags, res_flags;
  logic [IDW-1:0]  res_id;
  logic [34:0]     pd [L];
  logic [L-1:0]    pv;
  int checks = 0, errors = 0, issued = 0, pops = 0;
  logic [36:0] exp_q[$], out_log[$], run_a[$];
  int issue_log[$];
  typedef struct {int k; logic [31:0] op; logic [31:0] res; logic [2:0] fl;} vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  ipsxe_floating_point_log_arb_v1_0 dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_aclken(aclken),
    .i_req_data(req_data), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .o_core_data(core_data), .o_core_valid(core_in_valid),
    .i_core_result(core_result), .i_core_flags(core_flags), .i_core_valid(core_valid),
    .o_res_data(res_data), .o_res_id(res_id), .o_res_flags(res_flags), .o_res_valid(res_valid),
    .i_res_ready(res_ready), .i_drain_req(drain), .o_drained(drained), .o_err_orphan(orphan)
  );

  function automatic logic [34:0] core_fn(input logic [31:0] x);
    if (x[30:0] == 31'd0) return {32'hFF80_0000, 3'b000};
    if (x[31]) return {32'hFFC0_0000, 3'b100};
    if (x == 32'h3F80_0000) return {32'h0000_0000, 3'b000};
    return {x ^ 32'h00FF_00FF, 3'b000};
  endfunction

  // Behavioural core: fixed latency L, shares clock enable and reset with the arbiter.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pv <= '0;
    else if (aclken) begin
      pv <= {pv[L-2:0], core_in_valid};
      pd[0] <= core_fn(core_data);
      for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
    end
  assign core_valid  = pv[L-1] | inj_v;
  assign core_result = pd[L-1][34:3];
  assign core_flags  = pd[L-1][2:0];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  // Scoreboard: push on request handshake, pop and compare on result handshake.
  always @(negedge clk)
    if (rst_n) begin
      for (int k = 0; k < NR; k++)
        if (req_ready[k] && req_valid[k]) begin
          exp_q.push_back({core_fn(req_data[k*W +: W]), 2'(k)});
          issue_log.push_back(k);
          issued++;
        end
      if (res_valid && res_ready && aclken) begin
        pops++;
        out_log.push_back({res_data, res_flags, res_id});
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_pop actual=%h expected=none", {res_data, res_flags, res_id});
        end else chk("sb_result", {res_data, res_flags, res_id}, exp_q.pop_front());
      end
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = '0;
    drain = 1'b0;
    aclken = 1'b1;
    exp_q.delete();
    out_log.delete();
    issue_log.delete();
    issued = 0;
    pops = 0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic drain_sb(input string name);
    int n = 0;
    res_ready = 1'b1;
    while ((exp_q.size() != 0 || res_valid) && n < 300) begin
      tick;
      n++;
    end
    chk(name, 64'(exp_q.size()), 0);
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_req"}, req_ready, 0);
    chk({name, "_core"}, {core_in_valid, core_data}, 0);
    chk({name, "_res"}, {res_valid, res_data, res_flags, res_id}, 0);
    chk({name, "_status"}, {drained, orphan}, 0);
  endtask

  initial begin
    logic [36:0] held;
    int n;
    tbl[0] = '{0, 32'h3F80_0000, 32'h0000_0000, 3'b000};
    tbl[1] = '{2, 32'hBF80_0000, 32'hFFC0_0000, 3'b100};
    tbl[2] = '{1, 32'h4000_0000, 32'h40FF_00FF, 3'b000};
    tbl[3] = '{3, 32'h0000_0000, 32'hFF80_0000, 3'b000};
    tbl[4] = '{3, 32'h3F00_0000, 32'h3FFF_00FF, 3'b000};
    tbl[5] = '{1, 32'hC049_0FDB, 32'hFFC0_0000, 3'b100};
    rst_n = 1'b0; aclken = 1'b1; req_valid = '1; req_data = '0;
    res_ready = 1'b0; drain = 1'b0; inj_v = 1'b0;
    tick;
    tick;
    check_outputs_zero("reset");
    req_valid = '0;
    rst_n = 1'b1;
    tick;
    res_ready = 1'b1;
    foreach (tbl[i]) begin
      req_data[tbl[i].k*W +: W] = tbl[i].op;
      req_valid = '0;
      req_valid[tbl[i].k] = 1'b1;
      #1;
      chk($sformatf("t%0d_ready", i), req_ready, 64'(1) << tbl[i].k);
      tick;
      req_valid = '0;
      chk($sformatf("t%0d_core_issue", i), {core_in_valid, core_data}, {1'b1, tbl[i].op});
      tick;
      chk($sformatf("t%0d_core_once", i), core_in_valid, 0);
      n = 0;
      while (!core_valid && n < 20) begin tick; n++; end
      chk($sformatf("t%0d_core_return", i), core_valid, 1);
      chk($sformatf("t%0d_res_empty", i), res_valid, 0);
      tick;
      chk($sformatf("t%0d_res", i), {res_valid, res_data, res_flags, res_id},
          {1'b1, tbl[i].res, tbl[i].fl, 2'(tbl[i].k)});
      tick;
      chk($sformatf("t%0d_res_popped", i), res_valid, 0);
    end
    inj_v = 1'b1;
    tick;
    inj_v = 1'b0;
    chk("orphan_set", {orphan, res_valid}, 2'b10);
    tick;
    chk("orphan_sticky", {orphan, 64'(exp_q.size())}, {1'b1, 64'd0});

    // Round-robin burst at full clock enable; its output stream is the reference for the gated run.
    do_reset;
    chk("orphan_cleared", orphan, 0);
    for (int k = 0; k < NR; k++) req_data[k*W +: W] = 32'h4000_0000 | k;
    res_ready = 1'b1;
    req_valid = '1;
    repeat (40) tick;
    req_valid = '0;
    drain_sb("rr_drain");
    chk("rr_issued", issued, 40);
    chk("rr_pops", pops, 40);
    foreach (issue_log[i]) chk($sformatf("rr_grant%0d", i), issue_log[i], i % NR);
    run_a = out_log;

    do_reset;
    res_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < 80; i++) begin
      aclken = (i % 2 == 0);
      #1;
      if (!aclken) chk("clken_ready_low", req_ready, 0);
      tick;
    end
    aclken = 1'b1;
    req_valid = '0;
    drain_sb("clken_drain");
    chk("clken_issued", issued, 40);
    chk("clken_len", out_log.size(), run_a.size());
    foreach (run_a[i]) if (i < out_log.size()) chk($sformatf("clken_stream%0d", i), out_log[i], run_a[i]);

    // Credits: with results stalled, exactly FIFO_DEPTH ops go out.
    do_reset;
    res_ready = 1'b0;
    req_valid = '1;
    repeat (40) tick;
    held = {res_data, res_flags, res_id};
    repeat (10) tick;
    chk("credit_hold", {res_valid, res_data, res_flags, res_id}, {1'b1, held});
    chk("credit_issued", issued, 32);
    chk("credit_blocked", req_ready, 0);
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    repeat (8) tick;
    chk("credit_one_more", issued, 33);
    chk("credit_blocked2", req_ready, 0);
    req_valid = '0;
    drain_sb("credit_drain");
    chk("credit_pops", pops, 33);

    // Drain with five ops outstanding.
    do_reset;
    res_ready = 1'b0;
    req_valid = '1;
    repeat (5) tick;
    req_valid = '0;
    drain = 1'b1;
    tick;
    req_valid = '1;
    #1;
    chk("drain_no_grant", req_ready, 0);
    repeat (10) tick;
    chk("drain_busy", {drained, 64'(issued)}, {1'b0, 64'd5});
    res_ready = 1'b1;
    n = 0;
    while (pops < 5 && n < 40) begin
      tick;
      n++;
      if (pops == 4) chk("drain_before_last", drained, 0);
    end
    chk("drain_pops", pops, 5);
    chk("drained", drained, 1);
    tick;
    chk("drained_hold", {drained, 64'(issued)}, {1'b1, 64'd5});
    drain = 1'b0;
    tick;
    chk("drain_release", {drained, req_ready}, {1'b0, 4'b0010});
    tick;
    req_valid = '0;
    chk("drain_resume_id", issue_log[issue_log.size()-1], 1);
    drain_sb("drain_final");

    // Reset in the middle of a burst.
    do_reset;
    res_ready = 1'b1;
    req_valid = '1;
    repeat (10) tick;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_outputs_zero("midrst");
    tick;
    rst_n = 1'b1;
    req_valid = '0;
    n = 0;
    repeat (10) begin
      tick;
      n += int'(res_valid | core_in_valid | core_valid);
    end
    chk("midrst_quiet", n, 0);
    chk("midrst_orphan", orphan, 0);
    chk("sb_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
